// File: rtl/controle_energia.sv
// controle_energia: power-state controller. Synchronizes and debounces the
// front-panel button, classifies short/long presses, and combines them with
// the inactivity timer's auto-shutdown pulse C to drive enable/off_pulse.
module controle_energia #(
    parameter int unsigned DEBOUNCE_T  = 4,
    parameter int unsigned LONGPRESS_T = 3000
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    input  logic C,
    output logic enable,
    output logic off_pulse
);

    typedef enum logic [1:0] {
        SOLTO        = 2'b00,
        PRESSIONANDO = 2'b01,
        SEGURANDO    = 2'b10
    } btn_t;

    typedef enum logic {
        DESLIGADO = 1'b0,
        LIGADO    = 1'b1
    } pwr_t;

    localparam logic [15:0] DEB = 16'(DEBOUNCE_T);
    localparam logic [15:0] LP  = 16'(LONGPRESS_T);

    logic        s1;
    logic        b_s;
    btn_t        btn;
    pwr_t        pwr;
    logic [15:0] tp;
    logic        long_ev;
    logic        short_ev;

    // Two-flop synchronizer for the asynchronous push button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            b_s <= 1'b0;
        end else begin
            s1  <= botao;
            b_s <= s1;
        end
    end

    // Press events are decoded from the current button state so the power
    // FSM reacts on the same edge the button FSM makes its decision
    always_comb begin
        long_ev  = (btn == PRESSIONANDO) && b_s && (tp == LP);
        short_ev = (btn == PRESSIONANDO) && !b_s && (tp >= DEB);
    end

    // Button FSM with saturating press counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn <= SOLTO;
            tp  <= '0;
        end else begin
            case (btn)
                SOLTO: begin
                    if (b_s) begin
                        btn <= PRESSIONANDO;
                        tp  <= 16'd1;
                    end else begin
                        tp  <= '0;
                    end
                end
                PRESSIONANDO: begin
                    if (!b_s) begin
                        btn <= SOLTO;
                    end else if (tp == LP) begin
                        btn <= SEGURANDO;
                    end else begin
                        tp  <= tp + 16'd1;
                    end
                end
                SEGURANDO: begin
                    if (!b_s) begin
                        btn <= SOLTO;
                    end
                end
                default: begin
                    btn <= SOLTO;
                    tp  <= '0;
                end
            endcase
        end
    end

    // Power FSM: long press, then auto-shutdown, then short-press toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwr       <= DESLIGADO;
            enable    <= 1'b0;
            off_pulse <= 1'b0;
        end else begin
            off_pulse <= 1'b0;
            if (long_ev || (C && pwr == LIGADO)) begin
                pwr       <= DESLIGADO;
                enable    <= 1'b0;
                off_pulse <= (pwr == LIGADO);
            end else if (short_ev) begin
                if (pwr == LIGADO) begin
                    pwr       <= DESLIGADO;
                    enable    <= 1'b0;
                    off_pulse <= 1'b1;
                end else begin
                    pwr    <= LIGADO;
                    enable <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_controle_energia.sv
// Self-checking bench for controle_energia (DEBOUNCE_T=4, LONGPRESS_T=20).
module tb_controle_energia;

    logic clk = 1'b0;
    logic rst;
    logic botao;
    logic C;
    logic enable;
    logic off_pulse;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned pulses = 0;

    controle_energia #(
        .DEBOUNCE_T (4),
        .LONGPRESS_T(20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .botao    (botao),
        .C        (C),
        .enable   (enable),
        .off_pulse(off_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned hold;
        logic        exp_en;
        int unsigned exp_pulses;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (off_pulse) pulses++;
    endtask

    task automatic press(input int unsigned hold);
        botao = 1'b1;
        repeat (hold) tick();
        botao = 1'b0;
        repeat (6) tick();
    endtask

    initial begin
        // hold, enable after, off_pulse count; applied in order from desligado
        vecs[0]  = '{8,  1'b1, 0};  // short press -> on
        vecs[1]  = '{2,  1'b1, 0};  // glitch
        vecs[2]  = '{8,  1'b0, 1};  // short press -> off
        vecs[3]  = '{8,  1'b1, 0};
        vecs[4]  = '{40, 1'b0, 1};  // long press from on
        vecs[5]  = '{40, 1'b0, 0};  // long press from off: no pulse
        vecs[6]  = '{3,  1'b0, 0};  // just below debounce
        vecs[7]  = '{4,  1'b1, 0};  // exactly debounce
        vecs[8]  = '{19, 1'b0, 1};
        vecs[9]  = '{20, 1'b1, 0};  // released as Tp reaches 20: still short
        vecs[10] = '{21, 1'b0, 1};  // one more cycle: long

        rst = 1'b1; botao = 1'b0; C = 1'b0;
        repeat (3) tick();
        chk("rst_enable", enable, 0);
        chk("rst_off_pulse", off_pulse, 0);
        chk("rst_tp", dut.tp, 0);
        rst = 1'b0;
        tick();

        // Short press timing: enable rises on the third edge after release
        botao = 1'b1;
        repeat (8) tick();
        botao = 1'b0;
        tick(); tick();
        chk("short_f1_en", enable, 0);
        tick();
        chk("short_f2_en", enable, 1);
        chk("short_off", off_pulse, 0);

        // Long press timing: counting the first edge that samples the press
        // as edge 0, enable falls at edge 22
        botao = 1'b1;
        repeat (22) tick();
        chk("long_e21_en", enable, 1);
        tick();
        chk("long_e22_en", enable, 0);
        chk("long_e22_off", off_pulse, 1);
        tick();
        chk("long_e23_off", off_pulse, 0);
        repeat (16) tick();
        botao = 1'b0;
        pulses = 0;
        repeat (6) tick();
        chk("long_release_pulses", pulses, 0);
        chk("long_release_en", enable, 0);

        // Auto-shutdown pulse
        press(8);
        chk("c_pre_en", enable, 1);
        C = 1'b1;
        tick();
        C = 1'b0;
        chk("c_en", enable, 0);
        chk("c_off", off_pulse, 1);
        tick();
        chk("c_off_end", off_pulse, 0);
        pulses = 0;
        C = 1'b1;
        tick();
        C = 1'b0;
        tick();
        chk("c_while_off_pulses", pulses, 0);
        chk("c_while_off_en", enable, 0);

        // C coincident with the short-press release edge
        press(8);
        botao = 1'b1;
        repeat (8) tick();
        botao = 1'b0;
        tick(); tick();
        C = 1'b1;
        pulses = 0;
        tick();
        C = 1'b0;
        chk("coinc_en", enable, 0);
        chk("coinc_off", off_pulse, 1);
        repeat (8) tick();
        chk("coinc_pulses", pulses, 1);
        chk("coinc_final_en", enable, 0);

        // Asynchronous reset mid-press while on
        press(8);
        botao = 1'b1;
        repeat (12) tick();
        chk("rstmid_tp_before", dut.tp, 10);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_en", enable, 0);
        chk("rstmid_off", off_pulse, 0);
        chk("rstmid_tp", dut.tp, 0);
        #2 rst = 1'b0;
        tick(); tick(); tick();
        chk("rstmid_new_press_tp", dut.tp, 1);
        botao = 1'b0;
        repeat (6) tick();
        chk("rstmid_glitch_en", enable, 0);

        // Table-driven press sequence from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 11; i++) begin
            pulses = 0;
            press(vecs[i].hold);
            chk($sformatf("vec%0d_en", i), enable, vecs[i].exp_en);
            chk($sformatf("vec%0d_pulses", i), pulses, vecs[i].exp_pulses);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/controle_energia.md
# controle_energia

Power-state controller for the controller datapath: it consumes the one-cycle auto-shutdown pulse `C` from the inactivity timer and drives the `enable` line that timer counts against. A raw front-panel push button is synchronized and debounced. A short press toggles the device ON/OFF and a long press forces it OFF. The `enable` output feeds both the inactivity timer and the load driver, and `off_pulse` marks every ON→OFF transition.

## Interface
- `DEBOUNCE_T`, 4: minimum held cycles for a press to count; must be ≥ 1.
- `LONGPRESS_T`, 3000: held cycles at which a press becomes a long press; constraint DEBOUNCE_T < LONGPRESS_T ≤ 65535.
- `clk` input 1: system clock. One clock domain only.
- `rst` input 1: reset, asynchronous, active-high.
- `botao` input 1: raw push button, active-high, asynchronous to `clk`.
- `C` input 1: auto-shutdown pulse from the inactivity timer, one cycle wide, synchronous.
- `enable` output 1: device ON. Registered.
- `off_pulse` output 1: one-cycle pulse on each ON→OFF transition. Registered.

## Operation
- `botao` passes through a 2-flop synchronizer (`b_s`) before any logic. The synchronizer flops reset to 0.
- Press counter `Tp` is 16 bits and saturates at LONGPRESS_T. It never wraps.
- Button FSM `{solto, pressionando, segurando}`:
  - solto: Tp←0. If b_s=1, go to pressionando with Tp←1.
  - pressionando, b_s=1, Tp<LONGPRESS_T: Tp←Tp+1.
  - pressionando, b_s=1, Tp==LONGPRESS_T: go to segurando. This is a long-press event.
  - pressionando, b_s=0: go to solto. If Tp≥DEBOUNCE_T, this is a short-press event. Otherwise it is a glitch and is ignored.
  - segurando: if b_s=0, go to solto. Otherwise stay. No further events while held.
  - Any illegal encoding goes to solto.
- Power FSM `{desligado, ligado}`. Priority order:
  1. Long-press event: go to desligado.
  2. `C`=1 while ligado: go to desligado.
  3. Short-press event: toggle.
- Because of this priority, `C` and a short-press release in the same cycle while ligado give desligado. The press is discarded and the device does not toggle back on.
- `C` while desligado is ignored.
- A long press while desligado leaves the FSM in desligado and does not assert `off_pulse`.
- `enable` = (power state == ligado), registered together with the state.
- `off_pulse` = 1 for exactly the cycle after any ligado→desligado transition, whatever the cause.

## Timing
- Reset values: `enable`=0, `off_pulse`=0, power=desligado, button=solto, Tp=0, synchronizer=00.
- Reset mid-press: everything returns to reset values immediately. A button still held after `rst` deasserts is treated as a new press, counted from 1.
- Sync latency: `b_s` follows `botao` 2 clocks later.
- Short press: `botao` held N cycles, with DEBOUNCE_T ≤ N < LONGPRESS_T. `enable` toggles on the edge that samples b_s=0, which is 3 clocks after `botao` falls.
- Long press: `enable` falls on the edge where Tp==LONGPRESS_T is sampled, which is LONGPRESS_T+2 clocks after `botao` rises. `off_pulse` is high during the following cycle. Releasing the button afterwards causes no event.
- Auto-shutdown: `C` high on edge k means `enable`=0 after edge k, and `off_pulse`=1 between edge k and edge k+1.
- `enable` returning to 0 makes the inactivity timer return to its initial state. No handshake is needed: `C` is a pulse and is not acknowledged.
- Press shorter than DEBOUNCE_T cycles: no change to any output.

## Test plan
Bench parameters: DEBOUNCE_T=4, LONGPRESS_T=20.
1. Reset. Then hold `botao` for 8 cycles and release → `enable` rises 3 clocks after release. `off_pulse` stays 0.
2. From ligado, hold `botao` for 2 cycles → no change. Then hold it for 8 cycles → `enable` falls 3 clocks after release and `off_pulse` is high for exactly 1 cycle.
3. From ligado, hold `botao` for 40 cycles → `enable` falls 22 clocks after press start with one `off_pulse`. No change on release.
4. From ligado, pulse `C` for 1 cycle → `enable` = 0 on the next edge with one `off_pulse`. A further `C` while desligado → no `off_pulse`.
5. From ligado, time the short-press release so b_s=0 is sampled in the same cycle as `C`=1 → final state desligado, one `off_pulse`, no re-toggle on later cycles.
6. Assert `rst` asynchronously at Tp=10 of a press while ligado → `enable`, `off_pulse` and Tp are 0 immediately, before the next clock edge.
